branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: clk  input  1  clock, all state updates on rising edge; rst_n  input  1  async active-low reset.
REQ-002 The block SHALL have the following inputs:
- memory_stall  input  1  freezes all state
- flush_in  input  1  predictor redirect; squashes younger in-flight instructions
- instructionPC_1  input  32  fetch-stage PC
- instruction_1  input  32  fetch-stage instruction word
- pred_taken_1  input  1  predictor's taken prediction for instructionPC_1
- rs1_data_3, rs2_data_3  input  32 each  forwarded operands of the stage-3 instruction
REQ-003 The block SHALL have the following outputs:
- instructionPC_3  output  8  PC[7:0] of the stage-3 instruction
- is_branchInst_3  output  1  valid predictable branch in stage 3
- taken_3  output  1  resolved outcome
- prev_taken_3  output  1  prediction carried from fetch
- target_3  output  8  correct next PC[7:0]
- mispredict_cnt  output  16  saturating mispredict count
- branch_cnt  output  16  saturating resolved-branch count

Function
REQ-004 Two pipeline registers SHALL be implemented:
- S2 (fetch->decode): valid, PC, instruction, prediction.
- S3 (decode->resolve): valid, PC, decoded class, funct3, sign-extended immediate, prediction.
REQ-005 Decode in S2->S3 SHALL classify instructions as follows:
- opcode 1100011 with funct3 in {000,001,100,101,110,111}: BRANCH, B-type immediate.
- opcode 1101111: JAL, J-type immediate.
- Everything else, including JALR and funct3 010/011: NONE.
REQ-006 Stage-3 outputs SHALL be combinational from S3 and rs*_data_3:
- is_branchInst_3 = valid3 & (class != NONE).
- prev_taken_3 = valid3 & pred3.
- instructionPC_3 = pc3[7:0].
REQ-007 taken_3 SHALL be resolved as follows:
- JAL: 1.
- beq: equal. bne: not equal.
- blt/bge: signed less-than / not less-than.
- bltu/bgeu: unsigned less-than / not less-than.
- Forced 0 when is_branchInst_3 = 0.
REQ-008 target_3 SHALL equal (pc3 + imm)[7:0] when taken_3 = 1, and (pc3 + 4)[7:0] otherwise; additions SHALL be 32-bit modulo 2^32 with truncation.
REQ-009 When memory_stall = 1, S2, S3 and both counters SHALL hold their values; outputs SHALL continue to reflect the held S3 state.
REQ-010 When memory_stall = 0 and flush_in = 0, S2 SHALL load {1, instructionPC_1, instruction_1, pred_taken_1} and S3 SHALL load the decoded S2 contents.
REQ-011 When memory_stall = 0 and flush_in = 1, S2.valid and S3.valid SHALL both clear at the next edge; memory_stall SHALL take priority over flush_in.
REQ-012 branch_cnt SHALL increment at an edge when memory_stall = 0 and is_branchInst_3 = 1.
REQ-013 mispredict_cnt SHALL increment at an edge when memory_stall = 0, is_branchInst_3 = 1 and taken_3 != prev_taken_3.
REQ-014 Both counters SHALL saturate at 0xFFFF and never wrap.
REQ-015 A resolved branch SHALL appear on the stage-3 outputs exactly two unstalled edges after it is presented on the stage-1 inputs.

Reset
REQ-016 While rst_n = 0, all valid bits, S2/S3 contents and both counters SHALL be 0, asynchronously.
REQ-017 While rst_n = 0, all outputs SHALL be 0, except target_3, which SHALL be 0x04.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight instructions; the first valid S3 SHALL occur two unstalled edges after reset release.

Verification
REQ-019 Correctly predicted taken: beq at PC 0x40, imm +16, rs1 = rs2 = 5, pred 1, no stall -> after 2 edges is_branchInst_3 = 1, taken_3 = 1, prev_taken_3 = 1, target_3 = 0x50; mispredict_cnt stays 0 and branch_cnt becomes 1.
REQ-020 Signed/unsigned compare: blt and bltu at PC 0x80, imm -8, rs1 = 0xFFFFFFFF, rs2 = 1, pred 0 -> blt: taken_3 = 1, target_3 = 0x78, mispredict_cnt +1; bltu: taken_3 = 0, target_3 = 0x84, mispredict_cnt unchanged.
REQ-021 Stall hold: JAL in S3 with memory_stall = 1 for 3 cycles -> outputs constant and counters unchanged for all 3 cycles; counters increment exactly once on the first unstalled edge.
REQ-022 Flush: flush_in = 1 for one unstalled edge while bne occupies S2 -> that bne never asserts is_branchInst_3; with memory_stall = 1 in the same cycle, the flush is ignored.
REQ-023 Non-branch filtering: JALR, ADD, and opcode 1100011 with funct3 = 010 -> is_branchInst_3 = 0, taken_3 = 0, counters unchanged.
REQ-024 Saturation and reset: preload mispredict_cnt = 0xFFFF, then issue a mispredict -> stays 0xFFFF; assert rst_n = 0 mid-stream -> all outputs 0 and target_3 = 0x04 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution pipeline: fetch -> decode -> resolve.
// Two pipeline registers carry a fetched instruction to stage 3, where
// conditional branches and JAL are resolved against the forwarded operands.
// The correct next PC is produced, and resolved branches and mispredictions
// are counted in saturating counters.
module branch_resolve (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memory_stall,
    input  logic        flush_in,
    input  logic [31:0] instructionPC_1,
    input  logic [31:0] instruction_1,
    input  logic        pred_taken_1,
    input  logic [31:0] rs1_data_3,
    input  logic [31:0] rs2_data_3,
    output logic [7:0]  instructionPC_3,
    output logic        is_branchInst_3,
    output logic        taken_3,
    output logic        prev_taken_3,
    output logic [7:0]  target_3,
    output logic [15:0] mispredict_cnt,
    output logic [15:0] branch_cnt
);

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_JAL    = 2'd2
    } inst_class_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // S2: fetch -> decode
    logic        s2_valid_reg;
    logic [31:0] s2_pc_reg;
    logic [31:0] s2_instr_reg;
    logic        s2_pred_reg;

    // S3: decode -> resolve
    logic        s3_valid_reg;
    logic [31:0] s3_pc_reg;
    inst_class_e s3_class_reg;
    logic [2:0]  s3_funct3_reg;
    logic [31:0] s3_imm_reg;
    logic        s3_pred_reg;

    // Decoded S2 contents, loaded into S3
    inst_class_e dec_class_next;
    logic [31:0] dec_imm_next;

    // Fetch register: a flush kills the incoming instruction; a stall freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_pc_reg    <= 32'd0;
            s2_instr_reg <= 32'd0;
            s2_pred_reg  <= 1'b0;
        end else if (!memory_stall) begin
            s2_valid_reg <= !flush_in;
            s2_pc_reg    <= instructionPC_1;
            s2_instr_reg <= instruction_1;
            s2_pred_reg  <= pred_taken_1;
        end
    end

    // Classify the S2 instruction and extract its sign-extended immediate.
    // The funct3 values 010/011 are not branches, and JALR is left unpredicted.
    always_comb begin
        dec_class_next = CLS_NONE;
        dec_imm_next   = 32'd0;
        if (s2_instr_reg[6:0] == OPC_BRANCH && s2_instr_reg[14:13] != 2'b01) begin
            dec_class_next = CLS_BRANCH;
            dec_imm_next   = {{20{s2_instr_reg[31]}}, s2_instr_reg[7],
                              s2_instr_reg[30:25], s2_instr_reg[11:8], 1'b0};
        end else if (s2_instr_reg[6:0] == OPC_JAL) begin
            dec_class_next = CLS_JAL;
            dec_imm_next   = {{12{s2_instr_reg[31]}}, s2_instr_reg[19:12],
                              s2_instr_reg[20], s2_instr_reg[30:21], 1'b0};
        end
    end

    // Decode register: a flush also squashes the instruction leaving S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_reg  <= 1'b0;
            s3_pc_reg     <= 32'd0;
            s3_class_reg  <= CLS_NONE;
            s3_funct3_reg <= 3'd0;
            s3_imm_reg    <= 32'd0;
            s3_pred_reg   <= 1'b0;
        end else if (!memory_stall) begin
            s3_valid_reg  <= s2_valid_reg && !flush_in;
            s3_pc_reg     <= s2_pc_reg;
            s3_class_reg  <= dec_class_next;
            s3_funct3_reg <= s2_instr_reg[14:12];
            s3_imm_reg    <= dec_imm_next;
            s3_pred_reg   <= s2_pred_reg;
        end
    end

    logic        ops_eq;
    logic        ops_lt;
    logic        ops_ltu;
    logic        cond_taken;
    logic [31:0] target_full;
    logic [23:0] unused_target_hi;

    assign ops_eq  = (rs1_data_3 == rs2_data_3);
    assign ops_lt  = ($signed(rs1_data_3) < $signed(rs2_data_3));
    assign ops_ltu = (rs1_data_3 < rs2_data_3);

    // Evaluate the branch condition selected by funct3
    always_comb begin
        cond_taken = 1'b0;
        case (s3_funct3_reg)
            3'b000:  cond_taken = ops_eq;
            3'b001:  cond_taken = !ops_eq;
            3'b100:  cond_taken = ops_lt;
            3'b101:  cond_taken = !ops_lt;
            3'b110:  cond_taken = ops_ltu;
            3'b111:  cond_taken = !ops_ltu;
            default: cond_taken = 1'b0;
        endcase
    end

    // Stage-3 outputs; the target is computed at full width and the low byte is reported
    always_comb begin
        is_branchInst_3 = s3_valid_reg && (s3_class_reg != CLS_NONE);
        prev_taken_3    = s3_valid_reg && s3_pred_reg;
        instructionPC_3 = s3_pc_reg[7:0];
        taken_3         = 1'b0;
        if (is_branchInst_3) begin
            taken_3 = (s3_class_reg == CLS_JAL) ? 1'b1 : cond_taken;
        end
        target_full = taken_3 ? (s3_pc_reg + s3_imm_reg) : (s3_pc_reg + 32'd4);
        target_3    = target_full[7:0];
    end

    assign unused_target_hi = target_full[31:8];

    logic [1:0] cnt_inc;
    assign cnt_inc[0] = !memory_stall && is_branchInst_3;
    assign cnt_inc[1] = !memory_stall && is_branchInst_3 && (taken_3 != prev_taken_3);

    // Counter 0 counts resolved branches, counter 1 counts mispredictions
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            // Saturating count: holds at all-ones instead of wrapping
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= 16'd0;
                end else if (cnt_inc[gi] && cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign branch_cnt     = g_cnt[0].cnt_reg;
    assign mispredict_cnt = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: a table of fetched instructions
// is pushed into a scoreboard queue as it is driven and compared when it
// reaches stage 3. Hand-written sequences cover stall, flush, saturation
// and asynchronous reset.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memory_stall = 1'b0;
    logic        flush_in = 1'b0;
    logic [31:0] instructionPC_1 = 32'd0;
    logic [31:0] instruction_1 = 32'd0;
    logic        pred_taken_1 = 1'b0;
    logic [31:0] rs1_data_3 = 32'd0;
    logic [31:0] rs2_data_3 = 32'd0;
    logic [7:0]  instructionPC_3;
    logic        is_branchInst_3;
    logic        taken_3;
    logic        prev_taken_3;
    logic [7:0]  target_3;
    logic [15:0] mispredict_cnt;
    logic [15:0] branch_cnt;

    branch_resolve dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .memory_stall    (memory_stall),
        .flush_in        (flush_in),
        .instructionPC_1 (instructionPC_1),
        .instruction_1   (instruction_1),
        .pred_taken_1    (pred_taken_1),
        .rs1_data_3      (rs1_data_3),
        .rs2_data_3      (rs2_data_3),
        .instructionPC_3 (instructionPC_3),
        .is_branchInst_3 (is_branchInst_3),
        .taken_3         (taken_3),
        .prev_taken_3    (prev_taken_3),
        .target_3        (target_3),
        .mispredict_cnt  (mispredict_cnt),
        .branch_cnt      (branch_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP  = 32'h002081B3;  // add x3, x1, x2
    localparam logic [31:0] JALR = 32'h010080E7;  // jalr x1, 16(x1)

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        isb;
        logic        taken;
        logic [7:0]  tgt;
    } vec_t;

    localparam int N = 16;
    vec_t tbl [N];
    vec_t sb_q[$];
    vec_t e;

    int checks = 0;
    int errors = 0;
    int exp_b  = 0;
    int exp_m  = 0;

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [31:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic pred,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic isb, input logic taken, input logic [7:0] tgt);
        vec_t v;
        v.pc = pc; v.instr = instr; v.pred = pred; v.rs1 = rs1; v.rs2 = rs2;
        v.isb = isb; v.taken = taken; v.tgt = tgt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [7:0] pc, input logic isb,
                           input logic taken, input logic prev, input logic [7:0] tgt);
        chk({name, ".pc"},     {24'd0, instructionPC_3}, {24'd0, pc});
        chk({name, ".isb"},    {31'd0, is_branchInst_3}, {31'd0, isb});
        chk({name, ".taken"},  {31'd0, taken_3},         {31'd0, taken});
        chk({name, ".prev"},   {31'd0, prev_taken_3},    {31'd0, prev});
        chk({name, ".target"}, {24'd0, target_3},        {24'd0, tgt});
        chk({name, ".bcnt"},   {16'd0, branch_cnt},      exp_b);
        chk({name, ".mcnt"},   {16'd0, mispredict_cnt},  exp_m);
        $display("%s: pc=%02h isb=%0b taken=%0b prev=%0b target=%02h bcnt=%0d mcnt=%0d",
                 name, instructionPC_3, is_branchInst_3, taken_3, prev_taken_3, target_3,
                 branch_cnt, mispredict_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
        instructionPC_1 = pc;
        instruction_1   = instr;
        pred_taken_1    = pred;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(32'h40, enc_b(3'b000, 32'd16), 1'b1, 32'd5, 32'd5, 1'b1, 1'b1, 8'h50);
        tbl[1]  = mk(32'h80, enc_b(3'b100, 32'hFFFFFFF8), 1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 8'h78);
        tbl[2]  = mk(32'h80, enc_b(3'b110, 32'hFFFFFFF8), 1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 8'h84);
        tbl[3]  = mk(32'h100, enc_b(3'b001, 32'h20), 1'b0, 32'd3, 32'd4, 1'b1, 1'b1, 8'h20);
        tbl[4]  = mk(32'h10, enc_b(3'b101, 32'd8), 1'b1, 32'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 8'h18);
        tbl[5]  = mk(32'h10, enc_b(3'b111, 32'd8), 1'b1, 32'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 8'h14);
        tbl[6]  = mk(32'h2FC, enc_j(32'h104), 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 8'h00);
        tbl[7]  = mk(32'hFC, enc_b(3'b000, 32'd8), 1'b0, 32'd1, 32'd2, 1'b1, 1'b0, 8'h00);
        tbl[8]  = mk(32'h20, JALR, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 8'h24);
        tbl[9]  = mk(32'h24, NOP, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 8'h28);
        tbl[10] = mk(32'h28, enc_b(3'b010, 32'd16), 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 8'h2C);
        tbl[11] = mk(32'hFFFFFFF0, enc_j(32'hFFFFFFF0), 1'b1, 32'd0, 32'd0, 1'b1, 1'b1, 8'hE0);
        tbl[12] = mk(32'h30, enc_b(3'b110, 32'h7FE), 1'b1, 32'd1, 32'd2, 1'b1, 1'b1, 8'h2E);
        tbl[13] = mk(32'h50, enc_b(3'b001, 32'd8), 1'b1, 32'd7, 32'd7, 1'b1, 1'b0, 8'h54);
        tbl[14] = mk(32'h0, NOP, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 8'h04);
        tbl[15] = mk(32'h0, NOP, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 8'h04);

        // Reset state, observed before any clock edge
        drive1(32'h0, NOP, 1'b0);
        #2;
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 8'h04);
        tick();
        rst_n = 1'b1;

        // Table: each entry resolves in stage 3 two edges after it is driven
        for (int k = 0; k < N; k++) begin
            drive1(tbl[k].pc, tbl[k].instr, tbl[k].pred);
            sb_q.push_back(tbl[k]);
            if (sb_q.size() >= 3) begin
                e = sb_q.pop_front();
                rs1_data_3 = e.rs1;
                rs2_data_3 = e.rs2;
                #1;
                chk_out($sformatf("vec%0d", k - 2), e.pc[7:0], e.isb, e.taken, e.pred, e.tgt);
                if (e.isb) begin
                    exp_b++;
                    if (e.taken != e.pred) exp_m++;
                end
            end
            tick();
        end
        sb_q.delete();

        // Stall hold: JAL sits in stage 3 for three stalled edges
        drive1(32'h60, enc_j(32'h10), 1'b0);
        tick();
        drive1(32'h0, NOP, 1'b0);
        tick();
        chk_out("stall_in", 8'h60, 1'b1, 1'b1, 1'b0, 8'h70);
        memory_stall = 1'b1;
        drive1(32'h90, enc_j(32'h20), 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("stall%0d", i), 8'h60, 1'b1, 1'b1, 1'b0, 8'h70);
        end
        drive1(32'h0, NOP, 1'b0);
        memory_stall = 1'b0;
        tick();
        exp_b++;
        exp_m++;
        chk_out("stall_release", 8'h00, 1'b0, 1'b0, 1'b0, 8'h04);

        // Flush while bne occupies S2: it must never resolve
        rs1_data_3 = 32'd1;
        rs2_data_3 = 32'd2;
        drive1(32'h44, enc_b(3'b001, 32'd8), 1'b0);
        tick();
        drive1(32'h0, NOP, 1'b0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("flush_a.isb", {31'd0, is_branchInst_3}, 32'd0);
        chk("flush_a.taken", {31'd0, taken_3}, 32'd0);
        tick();
        chk("flush_b.isb", {31'd0, is_branchInst_3}, 32'd0);
        chk("flush_b.taken", {31'd0, taken_3}, 32'd0);
        tick();
        chk_out("flush_c", 8'h00, 1'b0, 1'b0, 1'b0, 8'h04);

        // Flush during a stall is ignored: bne survives and resolves
        drive1(32'h44, enc_b(3'b001, 32'd8), 1'b0);
        tick();
        drive1(32'h0, NOP, 1'b0);
        memory_stall = 1'b1;
        flush_in = 1'b1;
        tick();
        memory_stall = 1'b0;
        flush_in = 1'b0;
        chk_out("stflush_hold", 8'h00, 1'b0, 1'b0, 1'b0, 8'h04);
        tick();
        chk_out("stflush_bne", 8'h44, 1'b1, 1'b1, 1'b0, 8'h4C);
        tick();
        exp_b++;
        exp_m++;
        chk_out("stflush_after", 8'h00, 1'b0, 1'b0, 1'b0, 8'h04);

        // Saturation: a continuous stream of mispredicted JALs
        drive1(32'h0, enc_j(32'd8), 1'b0);
        repeat (65600) tick();
        chk("sat.bcnt", {16'd0, branch_cnt}, 32'hFFFF);
        chk("sat.mcnt", {16'd0, mispredict_cnt}, 32'hFFFF);
        repeat (3) tick();
        chk("sat_hold.bcnt", {16'd0, branch_cnt}, 32'hFFFF);
        chk("sat_hold.mcnt", {16'd0, mispredict_cnt}, 32'hFFFF);
        $display("saturation: bcnt=%0h mcnt=%0h", branch_cnt, mispredict_cnt);

        // Asynchronous reset mid-stream, observed between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        exp_b = 0;
        exp_m = 0;
        chk_out("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 8'h04);

        // First valid stage 3 appears two edges after reset release
        tick();
        rst_n = 1'b1;
        rs1_data_3 = 32'd5;
        rs2_data_3 = 32'd5;
        drive1(32'h40, enc_b(3'b000, 32'd16), 1'b1);
        tick();
        chk("post_rst1.isb", {31'd0, is_branchInst_3}, 32'd0);
        drive1(32'h0, NOP, 1'b0);
        tick();
        chk_out("post_rst2", 8'h40, 1'b1, 1'b1, 1'b1, 8'h50);
        tick();
        exp_b++;
        chk_out("post_rst3", 8'h00, 1'b0, 1'b0, 1'b0, 8'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
